// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for Avalon-ST stream sources.
package avalon_st_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH_IN_BYTES = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } avalon_st_sender_sm_t;

  // Number of beats needed to carry len bytes.
  function automatic int unsigned ceil_div_beats(input int unsigned len,
                                                 input int unsigned bytes_per_beat);
    return (len + bytes_per_beat - 1) / bytes_per_beat;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: valid/ready handshake plus sop/eop/empty framing.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
);
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;
  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;

  modport master (output valid, sop, eop, empty, data, input ready);
  modport slave  (input valid, sop, eop, empty, data, output ready);
endinterface

// File: rtl/avalon_st_out_reg.sv
// Valid/ready holding register: holds under backpressure, supports accept-and-reload.
module avalon_st_out_reg #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EMPTY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               load_sop,
  input  logic               load_eop,
  input  logic [EMPTY_W-1:0] load_empty,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [DATA_W-1:0]  out_data,
  output logic               accept_c,
  output logic               can_load_c
);

  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic [DATA_W-1:0]  data_q, data_d;

  assign accept_c   = valid_q & out_ready;
  assign can_load_c = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      sop_d   = load_sop;
      eop_d   = load_eop;
      empty_d = load_empty;
      data_d  = load_data;
    end else if (accept_c) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_empty = empty_q;
  assign out_data  = data_q;

endmodule

// File: rtl/avalon_st_msg_sender.sv
// Frames a length-tagged message from an upstream word stream into one
// Avalon-ST packet with a single sop, a single eop and the correct empty.
module avalon_st_msg_sender
  import avalon_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES,
  parameter int unsigned MAX_MSG_LEN_BYTES   = 2048,
  parameter int unsigned LEN_WIDTH           = $clog2(MAX_MSG_LEN_BYTES + 1),
  parameter int unsigned EMPTY_WIDTH         = $clog2(DATA_WIDTH_IN_BYTES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  avalon_st_if.master                      msg_out,
  output logic                             len_error,
  output logic                             busy
);

  localparam int unsigned DATA_W = DATA_WIDTH_IN_BYTES * 8;
  localparam int unsigned CALC_W = LEN_WIDTH + 1;

  avalon_st_sender_sm_t   state_q, state_d;
  logic [CALC_W-1:0]      beats_left_q, beats_left_d;
  logic [EMPTY_WIDTH-1:0] last_empty_q, last_empty_d;
  logic                   first_q, first_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   len_error_q, len_error_d;

  logic                   cmd_legal_c;
  logic [CALC_W-1:0]      beats_total_c;
  logic                   consume_c;
  logic                   load_eop_c;
  logic [EMPTY_WIDTH-1:0] load_empty_c;
  logic                   accept_c;
  logic                   can_load_c;
  logic                   out_valid, out_sop, out_eop;
  logic [EMPTY_WIDTH-1:0] out_empty;
  logic [DATA_W-1:0]      out_data;

  assign cmd_legal_c   = (cmd_len != '0) &&
                         (CALC_W'(cmd_len) <= CALC_W'(MAX_MSG_LEN_BYTES));
  assign beats_total_c = CALC_W'(ceil_div_beats(32'(cmd_len), DATA_WIDTH_IN_BYTES));

  // Upstream is never drained while reset is asserted.
  assign data_in_ready = ~rst && (state_q == SEND) && (beats_left_q != '0) && can_load_c;
  assign consume_c     = data_in_valid & data_in_ready;
  assign load_eop_c    = (beats_left_q == CALC_W'(1));
  assign load_empty_c  = load_eop_c ? last_empty_q : '0;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    last_empty_d = last_empty_q;
    first_d      = first_q;
    len_error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_legal_c) begin
            state_d      = SEND;
            beats_left_d = beats_total_c;
            first_d      = 1'b1;
            last_empty_d = EMPTY_WIDTH'(beats_total_c * CALC_W'(DATA_WIDTH_IN_BYTES)
                                        - CALC_W'(cmd_len));
          end else begin
            len_error_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (consume_c) begin
          beats_left_d = beats_left_q - CALC_W'(1);
          first_d      = 1'b0;
        end
        if (accept_c && out_eop) begin
          state_d = IDLE;
        end
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      last_empty_q <= '0;
      first_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      last_empty_q <= last_empty_d;
      first_q      <= first_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      len_error_q  <= len_error_d;
    end
  end

  avalon_st_out_reg #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (consume_c),
    .load_sop   (first_q),
    .load_eop   (load_eop_c),
    .load_empty (load_empty_c),
    .load_data  (data_in),
    .out_ready  (msg_out.ready),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_empty  (out_empty),
    .out_data   (out_data),
    .accept_c   (accept_c),
    .can_load_c (can_load_c)
  );

  assign msg_out.valid = out_valid;
  assign msg_out.sop   = out_sop;
  assign msg_out.eop   = out_eop;
  assign msg_out.empty = out_empty;
  assign msg_out.data  = out_data;

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign len_error = len_error_q;

endmodule

// File: tb/tb_avalon_st_msg_sender.sv
// Directed bench for avalon_st_msg_sender: framing, backpressure, starvation, length errors, reset.
module tb_avalon_st_msg_sender;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [11:0]  cmd_len;
  logic [127:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic         len_error;
  logic         busy;

  int total, fails;
  int cur_msg, word_idx, acc_cnt, sop_cnt, eop_cnt, consumed;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) msg_if ();

  avalon_st_msg_sender dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .msg_out       (msg_if),
    .len_error     (len_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mkword(input int m, input int w);
    return {4{32'hD000_0000 | 32'(m * 256 + w)}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; track upstream consumption and downstream acceptance.
  task automatic tick();
    logic in_fire, out_fire;
    @(negedge clk);
    in_fire  = data_in_valid & data_in_ready;
    out_fire = msg_if.valid & msg_if.ready;
    if (out_fire) begin
      chk("beat_data", msg_if.data, mkword(cur_msg, acc_cnt));
      acc_cnt++;
      sop_cnt += int'(msg_if.sop);
      eop_cnt += int'(msg_if.eop);
    end
    @(posedge clk);
    #1;
    if (in_fire) begin
      consumed++;
      word_idx++;
      data_in = mkword(cur_msg, word_idx);
    end
  endtask

  task automatic start_msg(input int m);
    cur_msg       = m;
    word_idx      = 0;
    data_in       = mkword(m, 0);
    data_in_valid = 1'b1;
    acc_cnt       = 0;
    sop_cnt       = 0;
    eop_cnt       = 0;
    consumed      = 0;
  endtask

  task automatic send_cmd(input logic [11:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic s,
                          input logic e, input logic [3:0] emp);
    chk({tag, ".valid"}, msg_if.valid, v);
    chk({tag, ".sop"},   msg_if.sop,   s);
    chk({tag, ".eop"},   msg_if.eop,   e);
    chk({tag, ".empty"}, msg_if.empty, emp);
  endtask

  task automatic chk_counts(input string tag, input int beats, input int words);
    chk({tag, ".beats"}, acc_cnt, beats);
    chk({tag, ".sops"},  sop_cnt, 1);
    chk({tag, ".eops"},  eop_cnt, 1);
    chk({tag, ".words"}, consumed, words);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_beat(tag, 1'b0, 1'b0, 1'b0, 4'd0);
    chk({tag, ".data"},          msg_if.data,   128'd0);
    chk({tag, ".cmd_ready"},     cmd_ready,     1'b0);
    chk({tag, ".data_in_ready"}, data_in_ready, 1'b0);
    chk({tag, ".len_error"},     len_error,     1'b0);
    chk({tag, ".busy"},          busy,          1'b0);
  endtask

  initial begin
    total = 0; fails = 0;
    cur_msg = 0; word_idx = 0; acc_cnt = 0; sop_cnt = 0; eop_cnt = 0; consumed = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; data_in = '0; data_in_valid = 1'b0;
    msg_if.ready = 1'b1;

    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();
    chk("idle.cmd_ready", cmd_ready, 1'b1);
    chk("idle.busy", busy, 1'b0);

    // 40 bytes: three back-to-back beats, last empty 8
    start_msg(1);
    send_cmd(12'd40);
    chk("t1.cmd_ready_low", cmd_ready, 1'b0);
    chk("t1.busy", busy, 1'b1);
    chk("t1.data_in_ready", data_in_ready, 1'b1);
    chk("t1.no_early_valid", msg_if.valid, 1'b0);
    tick(); chk_beat("t1.b0", 1'b1, 1'b1, 1'b0, 4'd0);
    tick(); chk_beat("t1.b1", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); chk_beat("t1.b2", 1'b1, 1'b0, 1'b1, 4'd8);
    chk("t1.no_extra_ready", data_in_ready, 1'b0);
    tick();
    chk("t1.idle_valid", msg_if.valid, 1'b0);
    chk("t1.cmd_ready_back", cmd_ready, 1'b1);
    chk("t1.busy_off", busy, 1'b0);
    chk_counts("t1", 3, 3);

    // 16 bytes: single sop+eop beat
    start_msg(2);
    send_cmd(12'd16);
    tick(); chk_beat("t2a.b0", 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    chk("t2a.valid_off", msg_if.valid, 1'b0);
    chk("t2a.cmd_ready", cmd_ready, 1'b1);
    chk_counts("t2a", 1, 1);

    // 32 bytes: two beats, last empty 0
    start_msg(3);
    send_cmd(12'd32);
    tick(); chk_beat("t2b.b0", 1'b1, 1'b1, 1'b0, 4'd0);
    tick(); chk_beat("t2b.b1", 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("t2b.cmd_ready", cmd_ready, 1'b1);
    chk_counts("t2b", 2, 2);

    // Illegal lengths: single len_error pulse, nothing emitted
    data_in_valid = 1'b0;
    send_cmd(12'd0);
    chk("t3z.len_error", len_error, 1'b1);
    chk("t3z.cmd_ready", cmd_ready, 1'b1);
    chk("t3z.valid", msg_if.valid, 1'b0);
    chk("t3z.busy", busy, 1'b0);
    tick();
    chk("t3z.pulse_end", len_error, 1'b0);
    chk("t3z.valid2", msg_if.valid, 1'b0);
    send_cmd(12'd2049);
    chk("t3o.len_error", len_error, 1'b1);
    chk("t3o.cmd_ready", cmd_ready, 1'b1);
    chk("t3o.valid", msg_if.valid, 1'b0);
    tick();
    chk("t3o.pulse_end", len_error, 1'b0);
    chk("t3o.data_in_ready", data_in_ready, 1'b0);

    // 48 bytes with a 3-cycle sink stall on beat 1
    start_msg(4);
    send_cmd(12'd48);
    tick(); chk_beat("t4.b0", 1'b1, 1'b1, 1'b0, 4'd0);
    tick(); chk_beat("t4.b1", 1'b1, 1'b0, 1'b0, 4'd0);
    msg_if.ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_beat("t4.stall", 1'b1, 1'b0, 1'b0, 4'd0);
      chk("t4.stall_data", msg_if.data, mkword(4, 1));
      chk("t4.stall_in_ready", data_in_ready, 1'b0);
      tick();
    end
    chk_beat("t4.stall_end", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t4.stall_end_data", msg_if.data, mkword(4, 1));
    msg_if.ready = 1'b1;
    tick(); chk_beat("t4.b2", 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("t4.valid_off", msg_if.valid, 1'b0);
    chk_counts("t4", 3, 3);

    // 64 bytes with a 2-cycle upstream gap after beat 1
    start_msg(5);
    send_cmd(12'd64);
    tick(); chk_beat("t5.b0", 1'b1, 1'b1, 1'b0, 4'd0);
    tick(); chk_beat("t5.b1", 1'b1, 1'b0, 1'b0, 4'd0);
    data_in_valid = 1'b0;
    tick();
    chk("t5.gap1_valid", msg_if.valid, 1'b0);
    chk("t5.gap1_in_ready", data_in_ready, 1'b1);
    tick();
    chk("t5.gap2_valid", msg_if.valid, 1'b0);
    data_in_valid = 1'b1;
    tick(); chk_beat("t5.b2", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); chk_beat("t5.b3", 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("t5.cmd_ready", cmd_ready, 1'b1);
    chk_counts("t5", 4, 4);

    // Reset after beat 1 of an 80-byte message, then a clean single beat
    start_msg(6);
    send_cmd(12'd80);
    tick(); chk_beat("t6.b0", 1'b1, 1'b1, 1'b0, 4'd0);
    tick(); chk_beat("t6.b1", 1'b1, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    chk("t6.rst_in_ready", data_in_ready, 1'b0);
    tick();
    chk_reset_state("t6.rst");
    chk("t6.words", consumed, 2);
    rst = 1'b0;
    data_in_valid = 1'b0;
    tick();
    chk("t6.cmd_ready", cmd_ready, 1'b1);
    start_msg(7);
    send_cmd(12'd16);
    tick(); chk_beat("t6n.b0", 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    chk("t6n.valid_off", msg_if.valid, 1'b0);
    chk("t6n.cmd_ready", cmd_ready, 1'b1);
    chk_counts("t6n", 1, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
